// File: rtl/sram_rw_port_arbiter.sv
// ============================================================================
// Module  : sram_rw_port_arbiter
// Brief   : Two-requester round-robin front end for a 1-cycle-latency
//           single-port SRAM macro, with clear-on-reset sequencing.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sram_rw_port_arbiter #(
  parameter int ADDR_W        = 9,
  parameter int DATA_W        = 256,
  parameter int MASK_W        = 32,
  parameter int INIT_ON_RESET = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [MASK_W-1:0] req0_wmask,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [MASK_W-1:0] req1_wmask,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              resp0_valid,
  output logic [DATA_W-1:0] resp0_rdata,
  output logic              resp1_valid,
  output logic [DATA_W-1:0] resp1_rdata,
  output logic              sram_en,
  output logic              sram_wmode,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [MASK_W-1:0] sram_wmask,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              init_done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INIT = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_init_cnt;
  logic              r_rr;          // 0: req0 wins a tie, 1: req1 wins
  logic              r_resp0_valid;
  logic              r_resp1_valid;
  logic              r_init_done;

  logic w_run;
  logic w_grant0;
  logic w_grant1;

  assign w_run    = (r_state == ST_RUN);
  assign w_grant0 = w_run & req0_valid & (~req1_valid | ~r_rr);
  assign w_grant1 = w_run & req1_valid & (~req0_valid |  r_rr);

  assign req0_ready  = w_grant0;
  assign req1_ready  = w_grant1;
  assign resp0_valid = r_resp0_valid;
  assign resp1_valid = r_resp1_valid;
  assign resp0_rdata = sram_rdata;
  assign resp1_rdata = sram_rdata;
  assign init_done   = r_init_done;

  always_comb begin
    sram_en    = 1'b0;
    sram_wmode = 1'b0;
    sram_addr  = r_init_cnt;
    sram_wmask = '1;
    sram_wdata = '0;
    if (r_state == ST_INIT) begin
      sram_en    = 1'b1;
      sram_wmode = 1'b1;
    end else if (w_grant0) begin
      sram_en    = 1'b1;
      sram_wmode = req0_write;
      sram_addr  = req0_addr;
      sram_wmask = req0_wmask;
      sram_wdata = req0_wdata;
    end else if (w_grant1) begin
      sram_en    = 1'b1;
      sram_wmode = req1_write;
      sram_addr  = req1_addr;
      sram_wmask = req1_wmask;
      sram_wdata = req1_wdata;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_init_cnt    <= '0;
      r_rr          <= 1'b0;
      r_resp0_valid <= 1'b0;
      r_resp1_valid <= 1'b0;
      r_init_done   <= 1'b0;
    end else begin
      r_resp0_valid <= w_grant0 & ~req0_write;
      r_resp1_valid <= w_grant1 & ~req1_write;
      // Only a contended grant moves the pointer.
      if (w_run && req0_valid && req1_valid) begin
        r_rr <= ~r_rr;
      end
      case (r_state)
        ST_IDLE: begin
          if (INIT_ON_RESET != 0) begin
            r_state <= ST_INIT;
          end else begin
            r_state     <= ST_RUN;
            r_init_done <= 1'b1;
          end
        end
        ST_INIT: begin
          r_init_cnt <= r_init_cnt + 1'b1;
          if (r_init_cnt == '1) begin
            r_state     <= ST_RUN;
            r_init_done <= 1'b1;
          end
        end
        ST_RUN: begin
          r_state <= ST_RUN;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sram_rw_port_arbiter.sv
// ============================================================================
// Module  : tb_sram_rw_port_arbiter
// Brief   : Random and directed bench with a behavioural SRAM and reference.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_sram_rw_port_arbiter;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 256;
  localparam int MASK_W = 32;
  localparam int LANE_W = DATA_W / MASK_W;
  localparam int DEPTH  = 2 ** ADDR_W;

  logic              clock = 1'b0;
  logic              reset_n;
  logic              req0_valid, req0_write, req1_valid, req1_write;
  logic [ADDR_W-1:0] req0_addr, req1_addr;
  logic [MASK_W-1:0] req0_wmask, req1_wmask;
  logic [DATA_W-1:0] req0_wdata, req1_wdata;
  logic              req0_ready, req1_ready, resp0_valid, resp1_valid;
  logic [DATA_W-1:0] resp0_rdata, resp1_rdata;
  logic              sram_en, sram_wmode, init_done;
  logic [ADDR_W-1:0] sram_addr;
  logic [MASK_W-1:0] sram_wmask;
  logic [DATA_W-1:0] sram_wdata;
  logic [DATA_W-1:0] sram_rdata;

  int total = 0;
  int bad   = 0;

  sram_rw_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W), .INIT_ON_RESET(1)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_write(req0_write),
    .req0_addr(req0_addr), .req0_wmask(req0_wmask), .req0_wdata(req0_wdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_write(req1_write),
    .req1_addr(req1_addr), .req1_wmask(req1_wmask), .req1_wdata(req1_wdata),
    .resp0_valid(resp0_valid), .resp0_rdata(resp0_rdata),
    .resp1_valid(resp1_valid), .resp1_rdata(resp1_rdata),
    .sram_en(sram_en), .sram_wmode(sram_wmode), .sram_addr(sram_addr),
    .sram_wmask(sram_wmask), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .init_done(init_done)
  );

  always #5 clock = ~clock;

  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old_d,
                                              input logic [DATA_W-1:0] new_d,
                                              input logic [MASK_W-1:0] m);
    logic [DATA_W-1:0] r;
    r = old_d;
    for (int l = 0; l < MASK_W; l++)
      if (m[l]) r[l*LANE_W +: LANE_W] = new_d[l*LANE_W +: LANE_W];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [DATA_W-1:0] act,
                     input logic [DATA_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Macro model: masked write, registered read data one cycle later.
  logic [DATA_W-1:0] mem [DEPTH];
  initial begin
    for (int i = 0; i < DEPTH; i++)
      for (int w = 0; w < DATA_W / 32; w++) mem[i][w*32 +: 32] = $urandom;
    sram_rdata = '0;
  end
  always @(posedge clock) begin
    if (sram_en) begin
      if (sram_wmode) mem[sram_addr] <= merge(mem[sram_addr], sram_wdata, sram_wmask);
      else            sram_rdata     <= mem[sram_addr];
    end
  end

  // Reference: cycle count since release decides the phase; ref_mem tracks contents.
  logic [DATA_W-1:0] ref_mem [DEPTH];
  int                cyc = 0;
  bit                rr  = 1'b0;
  bit                pend0 = 1'b0, pend1 = 1'b0;
  logic [DATA_W-1:0] pend_data;
  bit                m_acc0 = 1'b0, m_acc1 = 1'b0;

  always @(negedge clock) begin
    bit g0, g1, run;
    if (!reset_n) begin
      chk("rst_init_done", {255'b0, init_done}, '0);
      chk("rst_sram_en", {255'b0, sram_en}, '0);
      chk("rst_ready", {254'b0, req1_ready, req0_ready}, '0);
      chk("rst_resp_valid", {254'b0, resp1_valid, resp0_valid}, '0);
      cyc = 0; rr = 1'b0; pend0 = 1'b0; pend1 = 1'b0; m_acc0 = 1'b0; m_acc1 = 1'b0;
    end else begin
      run = (cyc > DEPTH);
      chk("init_done", {255'b0, init_done}, {255'b0, run});
      chk("resp0_valid", {255'b0, resp0_valid}, {255'b0, pend0});
      chk("resp1_valid", {255'b0, resp1_valid}, {255'b0, pend1});
      if (pend0) chk("resp0_rdata", resp0_rdata, pend_data);
      if (pend1) chk("resp1_rdata", resp1_rdata, pend_data);
      g0 = 1'b0; g1 = 1'b0;
      if (run) begin
        if (req0_valid && req1_valid) begin
          g0 = !rr; g1 = rr; rr = !rr;
        end else begin
          g0 = req0_valid; g1 = req1_valid;
        end
      end
      chk("req0_ready", {255'b0, req0_ready}, {255'b0, g0});
      chk("req1_ready", {255'b0, req1_ready}, {255'b0, g1});
      pend0 = 1'b0; pend1 = 1'b0;
      if (cyc == 0) begin
        chk("idle_en", {255'b0, sram_en}, '0);
      end else if (!run) begin
        chk("init_en", {254'b0, sram_en, sram_wmode}, 256'd3);
        chk("init_addr", {{(DATA_W-ADDR_W){1'b0}}, sram_addr}, cyc - 1);
        chk("init_wmask", {{(DATA_W-MASK_W){1'b0}}, sram_wmask}, {{(DATA_W-MASK_W){1'b0}}, {MASK_W{1'b1}}});
        chk("init_wdata", sram_wdata, '0);
        ref_mem[cyc-1] = '0;
      end else begin
        chk("run_en", {255'b0, sram_en}, {255'b0, g0 | g1});
        if (g0 || g1) begin
          logic              w;
          logic [ADDR_W-1:0] a;
          logic [MASK_W-1:0] m;
          logic [DATA_W-1:0] d;
          w = g0 ? req0_write : req1_write;
          a = g0 ? req0_addr  : req1_addr;
          m = g0 ? req0_wmask : req1_wmask;
          d = g0 ? req0_wdata : req1_wdata;
          chk("run_wmode", {255'b0, sram_wmode}, {255'b0, w});
          chk("run_addr", {{(DATA_W-ADDR_W){1'b0}}, sram_addr}, {{(DATA_W-ADDR_W){1'b0}}, a});
          if (w) begin
            chk("run_wmask", {{(DATA_W-MASK_W){1'b0}}, sram_wmask}, {{(DATA_W-MASK_W){1'b0}}, m});
            chk("run_wdata", sram_wdata, d);
            ref_mem[a] = merge(ref_mem[a], d, m);
          end else begin
            pend_data = ref_mem[a];
            pend0 = g0; pend1 = g1;
          end
        end
      end
      m_acc0 = g0; m_acc1 = g1;
      if (cyc <= DEPTH) cyc++;
    end
  end

  task automatic step();
    @(posedge clock); #1;
  endtask

  function automatic logic [DATA_W-1:0] rnd_data();
    logic [DATA_W-1:0] r;
    for (int w = 0; w < DATA_W / 32; w++) r[w*32 +: 32] = $urandom;
    return r;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 9'd3; req0_wmask = '0; req0_wdata = '0;
    req1_valid = 1'b0; req1_write = 1'b0; req1_addr = '0;   req1_wmask = '0; req1_wdata = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("lit_rst_done", {255'b0, init_done}, '0);
    step();
    reset_n = 1'b1;

    // Init sweep: IDLE for one cycle, 512 clearing writes, then RUN.
    for (int k = 0; k <= DEPTH + 1; k++) begin
      @(negedge clock);
      if (k == 0) chk("lit_idle_en", {255'b0, sram_en}, '0);
      if (k == 1) chk("lit_init_first", {{(DATA_W-ADDR_W-1){1'b0}}, sram_en, sram_addr}, 256'h200);
      if (k == DEPTH) begin
        chk("lit_init_last", {{(DATA_W-ADDR_W){1'b0}}, sram_addr}, 256'd511);
        chk("lit_done_low", {255'b0, init_done}, '0);
        chk("lit_held_off", {255'b0, req0_ready}, '0);
      end
      if (k == DEPTH + 1) begin
        chk("lit_done_high", {255'b0, init_done}, 256'd1);
        chk("lit_first_accept", {255'b0, req0_ready}, 256'd1);
      end
    end
    step();
    req0_valid = 1'b0;
    @(negedge clock);
    chk("lit_first_resp", {255'b0, resp0_valid}, 256'd1);
    chk("lit_cleared_data", resp0_rdata, '0);

    // Write then read on req1.
    step();
    req1_valid = 1'b1; req1_write = 1'b1; req1_addr = 9'd5;
    req1_wdata = {32{8'hA5}}; req1_wmask = '1;
    step();
    req1_write = 1'b0;
    step();
    req1_valid = 1'b0;
    @(negedge clock);
    chk("lit_raw_valid", {254'b0, resp1_valid, resp0_valid}, 256'd2);
    chk("lit_raw_data", resp1_rdata, {32{8'hA5}});

    // Partial-mask write on req0.
    step();
    req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 9'd7;
    req0_wdata = '1; req0_wmask = 32'h0000_000F;
    step();
    req0_write = 1'b0;
    step();
    req0_valid = 1'b0;
    @(negedge clock);
    chk("lit_mask_data", resp0_rdata, {224'b0, 32'hFFFF_FFFF});

    // Contention: both valid continuously.
    step();
    req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 9'd1;
    req1_valid = 1'b1; req1_write = 1'b0; req1_addr = 9'd2;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      chk("lit_rr_grant0", {255'b0, req0_ready}, {255'b0, (i % 2) == 0});
      chk("lit_rr_grant1", {255'b0, req1_ready}, {255'b0, (i % 2) == 1});
      step();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Random traffic; a request that was not accepted is held unchanged.
    for (int n = 0; n < 2000; n++) begin
      step();
      if (!(req0_valid && !m_acc0)) begin
        req0_valid = ($urandom_range(0, 3) != 0);
        req0_write = $urandom_range(0, 1);
        req0_addr  = $urandom_range(0, 15);
        req0_wmask = $urandom;
        req0_wdata = rnd_data();
      end
      if (!(req1_valid && !m_acc1)) begin
        req1_valid = ($urandom_range(0, 3) != 0);
        req1_write = $urandom_range(0, 1);
        req1_addr  = $urandom_range(0, 15);
        req1_wmask = $urandom;
        req1_wdata = rnd_data();
      end
    end
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();

    // Reset in the cycle after an accepted read.
    req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 9'd5;
    step();
    req0_valid = 1'b0;
    reset_n = 1'b0;
    @(negedge clock);
    chk("lit_rst_drop_resp", {255'b0, resp0_valid}, '0);
    chk("lit_rst_done_low", {255'b0, init_done}, '0);
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    @(negedge clock);
    chk("lit_reinit_idle", {255'b0, sram_en}, '0);
    @(negedge clock);
    chk("lit_reinit_addr0", {{(DATA_W-ADDR_W-2){1'b0}}, sram_en, sram_wmode, sram_addr}, 256'h600);
    repeat (20) @(negedge clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
